// File: rtl/oai_n1_pipe.sv
// Pipelined per-lane OR-AND-INVERT: ZN = ~((|A operands) & B) through STAGES registers with a valid bit and HOLD stall.
// Optional toggle counter on the output is enabled by defining OAI_N1_PIPE_TOGGLE_CNT_EN.
module oai_n1_pipe #(
    parameter int NA     = 3,
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VLD_IN,
    input  logic            HOLD,
    input  logic [NA*W-1:0] A,
    input  logic [W-1:0]    B,
    output logic [W-1:0]    ZN,
    output logic            VLD_OUT,
    output logic            BUSY
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
    ,
    output logic [15:0]     TGL_CNT
`endif
);

    logic [W-1:0]      or_all;
    logic [W-1:0]      f;
    logic [W-1:0]      d_q [STAGES];
    logic [W-1:0]      d_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;

    always_comb begin
        or_all = '0;
        for (int k = 0; k < NA; k++) begin
            or_all = or_all | A[k*W +: W];
        end
        f = ~(or_all & B);
    end

    // Stage 0 loads f even for invalid beats; only the valid bit qualifies data.
    always_comb begin
        d_d = d_q;
        v_d = v_q;
        if (!HOLD) begin
            d_d[0] = f;
            v_d[0] = VLD_IN;
            for (int s = 1; s < STAGES; s++) begin
                d_d[s] = d_q[s-1];
                v_d[s] = v_q[s-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < STAGES; s++) begin
                d_q[s] <= '1;
            end
            v_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                d_q[s] <= d_d[s];
            end
            v_q <= v_d;
        end
    end

    assign ZN      = d_q[STAGES-1];
    assign VLD_OUT = v_q[STAGES-1];
    assign BUSY    = |v_q;

`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;
    logic [15:0]  cnt_q;
    logic [15:0]  cnt_d;

    // prev starts at all-ones so the first valid beat compares against the reset output.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (VLD_OUT && !HOLD) begin
            prev_d = ZN;
            if ((ZN != prev_q) && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= '1;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign TGL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_oai_n1_pipe.sv
// Self-checking bench for oai_n1_pipe: three instances (W=4/S=2, W=1/S=2, W=4/S=4) sharing clock, reset and control.
// Toggle counter scenario runs only when OAI_N1_PIPE_TOGGLE_CNT_EN is defined.
module tb_oai_n1_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic        hold;
    logic [11:0] a_in;
    logic [3:0]  b_in;
    logic [2:0]  a1_in;
    logic [0:0]  b1_in;

    logic [3:0]  zn_a;
    logic        vo_a;
    logic        busy_a;
    logic [0:0]  zn_b;
    logic        vo_b;
    logic        busy_b;
    logic [3:0]  zn_c;
    logic        vo_c;
    logic        busy_c;
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
    logic [15:0] tgl_a;
    logic [15:0] tgl_b;
    logic [15:0] tgl_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oai_n1_pipe #(.NA(3), .W(4), .STAGES(2)) dut_a (
        .CLK(clk), .RST(rst), .VLD_IN(vld_in), .HOLD(hold), .A(a_in), .B(b_in),
        .ZN(zn_a), .VLD_OUT(vo_a), .BUSY(busy_a)
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
        , .TGL_CNT(tgl_a)
`endif
    );

    oai_n1_pipe #(.NA(3), .W(1), .STAGES(2)) dut_b (
        .CLK(clk), .RST(rst), .VLD_IN(vld_in), .HOLD(hold), .A(a1_in), .B(b1_in),
        .ZN(zn_b), .VLD_OUT(vo_b), .BUSY(busy_b)
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
        , .TGL_CNT(tgl_b)
`endif
    );

    oai_n1_pipe #(.NA(3), .W(4), .STAGES(4)) dut_c (
        .CLK(clk), .RST(rst), .VLD_IN(vld_in), .HOLD(hold), .A(a_in), .B(b_in),
        .ZN(zn_c), .VLD_OUT(vo_c), .BUSY(busy_c)
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
        , .TGL_CNT(tgl_c)
`endif
    );

    // Reference: a lane is 0 only when its B bit is set and at least one operand bit is set.
    function automatic logic [3:0] oai4(input logic [11:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !(b[i] && (a[i] || a[4+i] || a[8+i]));
        end
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; vld_in = 1'b0; hold = 1'b0; a_in = '0; b_in = '0; a1_in = '0; b1_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vld_in = 1'b1; a_in = 12'hFFF; b_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (zn_a !== 4'h0 || vo_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: zn=%h vo=%b busy=%b exp zn=0 vo=1 busy=1", zn_a, vo_a, busy_a);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (zn_a !== 4'hF || vo_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: zn=%h vo=%b busy=%b exp zn=f vo=0 busy=0", zn_a, vo_a, busy_a);
        end
        vld_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_truth_latency;
        vld_in = 1'b1; a_in = {4'b0000, 4'b0010, 4'b0001}; b_in = 4'b0111;
        @(posedge clk);
        #1 vld_in = 1'b0;
        checks++;
        if (vo_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: vo=%b exp 0", vo_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vo_a !== 1'b1 || zn_a !== 4'b1100) begin
            errors++;
            $display("FAIL truth: zn=%b vo=%b exp zn=1100 vo=1", zn_a, vo_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (vo_a !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_valid: vo=%b exp 0", vo_a);
        end
    endtask

    task automatic test_exhaustive;
        logic [0:0] exp_q[$];
        logic [0:0] e;
        logic [4:0] idx;
        int run = 0;
        int maxrun = 0;
        int total = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 16) begin
                idx = 5'(cyc);
                vld_in = 1'b1; a1_in = idx[2:0]; b1_in = idx[3];
                exp_q.push_back((idx[3] && idx[2:0] != 3'b000) ? 1'b0 : 1'b1);
            end else begin
                vld_in = 1'b0;
            end
            @(posedge clk);
            #1;
            if (vo_b) begin
                total++; run++;
                if (run > maxrun) maxrun = run;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL exh_extra: unexpected beat zn=%b", zn_b);
                end else begin
                    e = exp_q.pop_front();
                    if (zn_b !== e) begin
                        errors++;
                        $display("FAIL exh_data: got %b exp %b", zn_b, e);
                    end
                end
            end else begin
                run = 0;
            end
        end
        checks++;
        if (total !== 16 || maxrun !== 16) begin
            errors++;
            $display("FAIL exh_stream: valid=%0d run=%0d exp 16 16", total, maxrun);
        end
    endtask

    task automatic test_stall;
        logic [3:0] exp_q[$];
        logic [3:0] e;
        logic [3:0] prev_zn;
        logic       prev_vo;
        logic       held;
        int got = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            vld_in = 1'b0; hold = 1'b0; a_in = '0; b_in = '0;
            case (cyc)
                0: begin vld_in = 1'b1; a_in = 12'h001; b_in = 4'hF; end
                1: begin vld_in = 1'b1; a_in = 12'h060; b_in = 4'hF; end
                2, 3, 4: begin vld_in = 1'b1; hold = 1'b1; a_in = 12'hFFF; b_in = 4'hF; end
                5: begin vld_in = 1'b1; a_in = 12'h800; b_in = 4'hC; end
                default: ;
            endcase
            if (vld_in && !hold) exp_q.push_back(oai4(a_in, b_in));
            held = hold; prev_zn = zn_a; prev_vo = vo_a;
            @(posedge clk);
            #1;
            if (held) begin
                checks++;
                if (zn_a !== prev_zn || vo_a !== prev_vo) begin
                    errors++;
                    $display("FAIL stall_frozen: zn=%h vo=%b exp zn=%h vo=%b", zn_a, vo_a, prev_zn, prev_vo);
                end
            end else if (vo_a) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra: unexpected beat zn=%h", zn_a);
                end else begin
                    e = exp_q.pop_front();
                    if (zn_a !== e) begin
                        errors++;
                        $display("FAIL stall_data: got %h exp %h", zn_a, e);
                    end
                end
            end
        end
        hold = 1'b0;
        checks++;
        if (got !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, %0d left, exp 3 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_q[$];
        logic [3:0] e;
        logic [3:0] prev_zn;
        logic       prev_vo;
        logic       held;
        for (int cyc = 0; cyc < 66; cyc++) begin
            if (cyc < 60) begin
                vld_in = ($urandom_range(0, 3) != 0);
                hold   = ($urandom_range(0, 4) == 0);
                a_in   = 12'($urandom_range(0, 4095));
                b_in   = 4'($urandom_range(0, 15));
            end else begin
                vld_in = 1'b0; hold = 1'b0;
            end
            if (vld_in && !hold) exp_q.push_back(oai4(a_in, b_in));
            held = hold; prev_zn = zn_a; prev_vo = vo_a;
            @(posedge clk);
            #1;
            if (held) begin
                checks++;
                if (zn_a !== prev_zn || vo_a !== prev_vo) begin
                    errors++;
                    $display("FAIL b2b_frozen: zn=%h vo=%b exp zn=%h vo=%b", zn_a, vo_a, prev_zn, prev_vo);
                end
            end else if (vo_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected beat zn=%h", zn_a);
                end else begin
                    e = exp_q.pop_front();
                    if (zn_a !== e) begin
                        errors++;
                        $display("FAIL b2b_data: got %h exp %h", zn_a, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drop: %0d beats left, exp 0", exp_q.size());
        end
    endtask

    task automatic test_deep_reset;
        logic [3:0] e;
        logic       seen = 1'b0;
        vld_in = 1'b1; hold = 1'b0; a_in = 12'h00F; b_in = 4'h3;
        e = oai4(a_in, b_in);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1 vld_in = 1'b0;
            checks++;
            if (vo_c !== (cyc == 4)) begin
                errors++;
                $display("FAIL deep_latency: edge %0d vo=%b exp %b", cyc, vo_c, (cyc == 4));
            end
            if (cyc == 4) begin
                checks++;
                if (zn_c !== e) begin
                    errors++;
                    $display("FAIL deep_data: got %h exp %h", zn_c, e);
                end
            end
        end
        vld_in = 1'b1; a_in = 12'hFFF; b_in = 4'hF;
        repeat (3) @(posedge clk);
        #1 vld_in = 1'b0;
        checks++;
        if (busy_c !== 1'b1 || vo_c !== 1'b0) begin
            errors++;
            $display("FAIL deep_inflight: busy=%b vo=%b exp busy=1 vo=0", busy_c, vo_c);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy_c !== 1'b0 || vo_c !== 1'b0 || zn_c !== 4'hF) begin
            errors++;
            $display("FAIL deep_reset: busy=%b vo=%b zn=%h exp 0 0 f", busy_c, vo_c, zn_c);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            if (vo_c || busy_c) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL deep_discard: flushed beat reappeared (seen=%b exp 0)", seen);
        end
    endtask

`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
    task automatic test_toggle_cnt;
        logic [11:0] ta[5];
        logic [3:0]  tb[5];
        ta = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h00F};
        tb = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hA};
        hold = 1'b0; vld_in = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (tgl_a !== 16'h0) begin
            errors++;
            $display("FAIL tgl_reset: got %h exp 0000", tgl_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vld_in = 1'b1; a_in = ta[i]; b_in = tb[i];
            @(posedge clk);
            #1;
        end
        vld_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (tgl_a !== 16'd2) begin
            errors++;
            $display("FAIL tgl_count: got %0d exp 2", tgl_a);
        end
        a_in = 12'hFFF;
        for (int i = 0; i < 70000; i++) begin
            vld_in = 1'b1; b_in = (i % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
        end
        vld_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (tgl_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL tgl_saturate: got %h exp ffff", tgl_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_truth_latency();
        test_exhaustive();
        test_stall();
        test_back_to_back();
        test_deep_reset();
`ifdef OAI_N1_PIPE_TOGGLE_CNT_EN
        test_toggle_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oai_n1_pipe.md
Name: oai_n1_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-input OR-AND-INVERT cell.
- Per bit lane: ZN = ~((A[0] | A[1] | ... | A[NA-1]) & B).
- The result is registered through STAGES flops, with a valid bit travelling alongside and a synchronous stall.
- Sits in datapath macros that need wide OAI reduction at clock rate with bounded latency.

Parameters:
NA, 3, number of OR-group inputs per lane (1..8)
W, 1, lane width in bits (1..64)
STAGES, 2, pipeline depth in cycles (1..4)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous active-high reset
VLD_IN  input  1  qualifies A/B this cycle
HOLD  input  1  stall; freezes the whole pipeline
A  input  NA*W  OR-group operands; operand k occupies A[k*W +: W]
B  input  W  AND operand
ZN  output  W  registered OAI result from the last stage
VLD_OUT  output  1  ZN qualifier from the last stage
BUSY  output  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Combinational core, bitwise per lane i: f[i] = ~((OR over k of A[k*W+i]) & B[i]). It is evaluated every cycle.
- Pipeline: stage registers d[0..STAGES-1] (W bits each) and v[0..STAGES-1] (1 bit each).
- Per rising CLK edge with HOLD=0:
  - d[0] <= f and v[0] <= VLD_IN.
  - d[s] <= d[s-1] and v[s] <= v[s-1].
- Data gating: when VLD_IN=0, d[0] still loads f. The data is don't-care but deterministic; only the valid bit marks it.
- Stall: HOLD=1 means no register changes, including d[0]. ZN and VLD_OUT keep their values.
- Outputs: ZN = d[STAGES-1], VLD_OUT = v[STAGES-1], BUSY = |v.
- Latency: a beat accepted at edge n (VLD_IN=1, HOLD=0) appears on ZN/VLD_OUT after edge n+STAGES-1, counting only non-held edges. STAGES=1 gives one-cycle registered output.
- Throughput: one beat per non-held cycle. There is no backpressure beyond HOLD.
- Reset:
  - Asserting RST immediately clears all d to all-ones and all v to 0. The output is then ZN = {W{1'b1}}, VLD_OUT = 0, BUSY = 0.
  - All-ones is the OAI value for all-zero inputs.
  - RST mid-stream discards in-flight beats with no partial output.
  - Deassertion is synchronised by the parent. The first edge after deassertion behaves normally.
- Simultaneous events:
  - RST dominates HOLD and VLD_IN.
  - HOLD dominates VLD_IN; a beat presented while HOLD=1 is not captured.
- X handling, simulation only: an X on any input lane propagates to that lane's f. Valid bits never go X unless VLD_IN or HOLD is X.

Optional Feature:
- Macro: OAI_N1_PIPE_TOGGLE_CNT_EN.
- Defined:
  - Adds output port TGL_CNT, 16 bits.
  - Counts the rising CLK edges where VLD_OUT=1, HOLD=0, and ZN differs from the previous valid ZN in at least one bit.
  - Saturates at 16'hFFFF with no wrap.
  - Reset clears it to 0. The first valid beat after reset compares against the all-ones reset value.
- Undefined: the port, counter and previous-value register are absent. All other behaviour is identical.

Test Plan:
1. Reset sequence: W=4, NA=3, STAGES=2. Assert RST mid-cycle -> ZN=4'hF, VLD_OUT=0, BUSY=0 before the next edge.
2. Truth and latency: one beat with A1=4'b0001, A2=4'b0010, A3=0, B=4'b0111, HOLD=0 -> after 2 edges ZN=4'b1100 and VLD_OUT=1 for exactly one cycle.
3. Exhaustive lane check: W=1, NA=3, all 16 A/B combinations streamed back-to-back -> ZN=0 only where B=1 and some A=1; VLD_OUT high for 16 consecutive cycles.
4. Stall: stream beats 1,2,3 and assert HOLD for 3 cycles after beat 2 enters -> ZN/VLD_OUT frozen during HOLD; output order 1,2,3 with no duplicate or drop; beat presented during HOLD is ignored.
5. Reset mid-flight: STAGES=4 with 3 beats in flight, pulse RST -> VLD_OUT never asserts for those beats; BUSY=0 immediately.
6. Toggle counter (macro defined): valid ZN sequence F,F,0,0,5 -> TGL_CNT=2. Force 70000 toggles -> TGL_CNT holds 16'hFFFF.
